pulse_meas_tim: RTL and testbench

- Capture-side counterpart of the strobe pulse generator. After an enable strobe it times the first rising and the following falling edge of an external pulse, both counted from the strobe.
- Results are absolute counts in the same units as the generator's delay and pulse-end settings, so the pair can be loop-back checked.
- Optional `tim` pre-count shortens the measurement window by the time spent before the strobe, for ADC-strobe alignment.

---
 rtl/pulse_meas_tim.sv | 211 +++++++++++++++++++++
 tb/tb_pulse_meas_tim.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas_tim.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_meas_tim
//  Purpose  : Pulse capture timer. After an enable strobe it measures the
//             first rising edge and the following falling edge of an
//             asynchronous input pulse. Both times are counted in clk cycles
//             from the strobe. An optional 'tim' pre-count, taken while idle,
//             shortens the measurement window by the time spent before the
//             strobe.
//  Ports    : clk            - system clock, rising edge
//             reset          - asynchronous reset, active low
//             enable         - start strobe, honoured only while idle
//             tim            - pre-strobe hold, counted while idle
//             sig_in         - asynchronous pulse under measurement
//             window_in      - nominal window length in clk cycles
//             rise_time_out  - counter value at the detected rising edge
//             fall_time_out  - counter value at the detected falling edge
//             rise_seen      - rising edge captured in the last measurement
//             fall_seen      - falling edge captured in the last measurement
//             done           - one-cycle pulse when a measurement ends
//             busy           - high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_meas_tim #(
    parameter int WIDTH     = 25,
    parameter int TIM_WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tim,
    input  logic             sig_in,
    input  logic [WIDTH-1:0] window_in,
    output logic [WIDTH-1:0] rise_time_out,
    output logic [WIDTH-1:0] fall_time_out,
    output logic             rise_seen,
    output logic             fall_seen,
    output logic             done,
    output logic             busy
);

    // Common width for comparing the window against the pre-count.
    localparam int c_CMP_W = (WIDTH > TIM_WIDTH) ? WIDTH : TIM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_WAIT_FALL = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_sync1;
    logic                   r_sig_s;
    logic                   r_sig_d;

    logic [WIDTH-1:0]       r_counter;
    logic [WIDTH-1:0]       r_window;
    logic [TIM_WIDTH-1:0]   r_count_tim;
    logic [WIDTH-1:0]       r_rise_time;
    logic [WIDTH-1:0]       r_fall_time;
    logic                   r_rise_seen;
    logic                   r_fall_seen;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_start;
    logic                   w_counting;
    logic                   w_timeout;
    logic                   w_cap_rise;
    logic                   w_cap_fall;
    logic [c_CMP_W-1:0]     w_win_ext;
    logic [c_CMP_W-1:0]     w_tim_ext;
    logic [WIDTH-1:0]       w_win_start;

    // ------------------------------------------------------------------
    // Edge detection on the synchronised input
    // ------------------------------------------------------------------
    assign w_rise = r_sig_s & ~r_sig_d;
    assign w_fall = ~r_sig_s & r_sig_d;

    // ------------------------------------------------------------------
    // Window compensation: the pre-count is subtracted only when it leaves
    // a positive window; otherwise the nominal window is used unchanged.
    // ------------------------------------------------------------------
    assign w_win_ext   = c_CMP_W'(window_in);
    assign w_tim_ext   = c_CMP_W'(r_count_tim);
    assign w_win_start = (w_win_ext > w_tim_ext) ? WIDTH'(w_win_ext - w_tim_ext)
                                                 : window_in;

    assign w_start    = (r_state == S_IDLE) && !tim && enable;
    assign w_counting = (r_state == S_WAIT_RISE) || (r_state == S_WAIT_FALL);
    assign w_timeout  = (r_counter >= r_window);
    assign w_cap_rise = (r_state == S_WAIT_RISE) && w_rise;
    assign w_cap_fall = (r_state == S_WAIT_FALL) && w_fall;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A timeout overrides the rise transition so that an
    // edge landing exactly on the window end is recorded but still ends
    // the measurement.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end else if (w_rise) begin
                    w_state_nxt = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (w_timeout || w_fall) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser plus one delay stage for edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sig_s <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sig_s <= r_sync1;
            r_sig_d <= r_sig_s;
        end
    end

    // ------------------------------------------------------------------
    // Counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_counter   <= '0;
            r_window    <= '0;
            r_count_tim <= '0;
            r_rise_time <= '0;
            r_fall_time <= '0;
            r_rise_seen <= 1'b0;
            r_fall_seen <= 1'b0;
        end else begin
            if (w_start) begin
                r_counter   <= '0;
                r_window    <= w_win_start;
                r_rise_time <= '0;
                r_fall_time <= '0;
                r_rise_seen <= 1'b0;
                r_fall_seen <= 1'b0;
            end else if (w_counting) begin
                // Leaves the WAIT states once counter reaches the window,
                // so this cannot wrap.
                r_counter <= r_counter + WIDTH'(1);
            end

            if (w_cap_rise) begin
                r_rise_time <= r_counter;
                r_rise_seen <= 1'b1;
            end

            if (w_cap_fall) begin
                r_fall_time <= r_counter;
                r_fall_seen <= 1'b1;
            end

            if (r_state == S_DONE) begin
                r_count_tim <= '0;
            end else if ((r_state == S_IDLE) && tim && (r_count_tim != '1)) begin
                r_count_tim <= r_count_tim + TIM_WIDTH'(1);
            end
        end
    end

    assign rise_time_out = r_rise_time;
    assign fall_time_out = r_fall_time;
    assign rise_seen     = r_rise_seen;
    assign fall_seen     = r_fall_seen;
    assign done          = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_meas_tim.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pulse_meas_tim
//  Purpose  : Self-checking bench for pulse_meas_tim. Each measurement is
//             described by a per-edge sample array of sig_in; expected
//             results are derived from that array with the timing rules of
//             the block (two-cycle synchroniser latency, counter = edges
//             since the strobe, window compensation by the tim pre-count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_meas_tim;

    localparam int WIDTH     = 25;
    localparam int TIM_WIDTH = 21;
    localparam int TIM_MAX   = (1 << TIM_WIDTH) - 1;
    localparam int NONE      = 100000;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             tim;
    logic             sig_in;
    logic [WIDTH-1:0] window_in;
    logic [WIDTH-1:0] rise_time_out;
    logic [WIDTH-1:0] fall_time_out;
    logic             rise_seen;
    logic             fall_seen;
    logic             done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tim_acc  = 0;

    // wave[i] is sig_in as sampled by edge j = i - 2, j counted from the
    // enable edge (j = 0).
    bit wave [0:299];

    pulse_meas_tim #(
        .WIDTH     (WIDTH),
        .TIM_WIDTH (TIM_WIDTH)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .tim           (tim),
        .sig_in        (sig_in),
        .window_in     (window_in),
        .rise_time_out (rise_time_out),
        .fall_time_out (fall_time_out),
        .rise_seen     (rise_seen),
        .fall_seen     (fall_seen),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit s_at(input int j);
        return wave[j + 2];
    endfunction

    // Level starts at init and toggles at edge indices tog_a and tog_b.
    task automatic mk_wave(input bit init, input int tog_a, input int tog_b);
        for (int i = 0; i < 300; i++) begin
            wave[i] = init ^ ((i - 2) >= tog_a) ^ ((i - 2) >= tog_b);
        end
    endtask

    task automatic rnd_wave();
        bit lvl;
        int p;
        int sel;
        lvl = 1'($urandom % 2);
        sel = int'($urandom % 4);
        p   = (sel == 0) ? 0 : (sel == 1) ? 3 : (sel == 2) ? 10 : 30;
        for (int i = 0; i < 300; i++) begin
            wave[i] = lvl;
            if (i >= 1 && int'($urandom % 100) < p) lvl = ~lvl;
        end
    endtask

    task automatic run_meas(input string name, input int win, input int tim_n,
                            input int en2_in, input int abort_at);
        int ctim, weff, rise_k, fall_k, end_k, first_done, done_cnt, last_j, en2;

        // Pre-strobe tim phase while idle.
        for (int i = 0; i < tim_n; i++) begin
            @(negedge clk);
            tim = 1'b1;
        end
        @(negedge clk);
        tim = 1'b0;
        tim_acc = tim_acc + tim_n;
        if (tim_acc > TIM_MAX) tim_acc = TIM_MAX;

        // Reference model.
        ctim = tim_acc;
        weff = (win > ctim) ? (win - ctim) : win;
        rise_k = -1;
        fall_k = -1;
        for (int k = 0; k <= weff; k++) begin
            if (s_at(k - 1) && !s_at(k - 2)) begin
                rise_k = k;
                break;
            end
        end
        if (rise_k >= 0) begin
            for (int k = rise_k + 1; k <= weff; k++) begin
                if (!s_at(k - 1) && s_at(k - 2)) begin
                    fall_k = k;
                    break;
                end
            end
        end
        end_k = (fall_k >= 0) ? fall_k : weff;
        en2   = (en2_in > end_k + 1) ? -1 : en2_in;

        window_in  = WIDTH'(win);
        first_done = -1;
        done_cnt   = 0;
        last_j     = (abort_at >= 0) ? abort_at : end_k + 4;

        for (int j = -2; j <= last_j; j++) begin
            @(negedge clk);
            // Observed values reflect the state after edge j-1.
            if (j >= 1 && done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = j - 1;
            end
            if (j == 1) chk_eq({name, ".busy_run"}, 32'(busy), 32'd1);
            if (abort_at >= 0 && j == abort_at) begin
                chk_eq({name, ".pre_rst_rise_seen"}, 32'(rise_seen), 32'(rise_k >= 0 && rise_k < j));
                reset = 1'b0;
                #1;
                chk_eq({name, ".rst_rise_time"}, 32'(rise_time_out), 32'd0);
                chk_eq({name, ".rst_fall_time"}, 32'(fall_time_out), 32'd0);
                chk_eq({name, ".rst_rise_seen"}, 32'(rise_seen), 32'd0);
                chk_eq({name, ".rst_fall_seen"}, 32'(fall_seen), 32'd0);
                chk_eq({name, ".rst_busy"}, 32'(busy), 32'd0);
                done_cnt = 0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (c == 4) reset = 1'b1;
                    if (done === 1'b1) done_cnt++;
                end
                chk_eq({name, ".rst_no_done"}, 32'(done_cnt), 32'd0);
                tim_acc = 0;
                enable  = 1'b0;
                return;
            end
            sig_in = s_at(j);
            enable = (j == 0) || (en2 >= 0 && j == en2);
        end
        enable = 1'b0;

        chk_eq({name, ".done_cycle"}, 32'(first_done), 32'(end_k + 1));
        chk_eq({name, ".done_count"}, 32'(done_cnt), 32'd1);
        chk_eq({name, ".busy_after"}, 32'(busy), 32'd0);
        chk_eq({name, ".rise_seen"}, 32'(rise_seen), 32'(rise_k >= 0));
        chk_eq({name, ".fall_seen"}, 32'(fall_seen), 32'(fall_k >= 0));
        chk_eq({name, ".rise_time"}, 32'(rise_time_out), 32'((rise_k >= 0) ? rise_k : 0));
        chk_eq({name, ".fall_time"}, 32'(fall_time_out), 32'((fall_k >= 0) ? fall_k : 0));
        tim_acc = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        tim       = 1'b0;
        sig_in    = 1'b0;
        window_in = '0;
        repeat (3) @(negedge clk);
        chk_eq("reset.rise_time", 32'(rise_time_out), 32'd0);
        chk_eq("reset.fall_time", 32'(fall_time_out), 32'd0);
        chk_eq("reset.rise_seen", 32'(rise_seen), 32'd0);
        chk_eq("reset.fall_seen", 32'(fall_seen), 32'd0);
        chk_eq("reset.done", 32'(done), 32'd0);
        chk_eq("reset.busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        mk_wave(1'b0, 11, 31);
        run_meas("loopback", 100, 0, -1, -1);

        mk_wave(1'b0, NONE, NONE);
        run_meas("no_pulse", 50, 0, -1, -1);

        mk_wave(1'b1, 6, 21);
        run_meas("stuck_high", 100, 0, -1, -1);

        mk_wave(1'b0, NONE, NONE);
        run_meas("tim30", 100, 30, -1, -1);

        mk_wave(1'b0, NONE, NONE);
        run_meas("tim150", 100, 150, -1, -1);

        mk_wave(1'b0, 4, 59);
        run_meas("busy_prot", 60, 0, 21, -1);

        mk_wave(1'b0, NONE, NONE);
        run_meas("window0", 0, 0, -1, -1);

        mk_wave(1'b0, 11, NONE);
        run_meas("rst_mid", 100, 0, -1, 41);

        mk_wave(1'b0, 11, 31);
        run_meas("after_rst", 100, 0, -1, -1);

        for (int t = 0; t < 30; t++) begin
            int win;
            int tn;
            int e2;
            win = int'($urandom_range(80, 0));
            tn  = ($urandom % 2 == 0) ? 0 : int'($urandom_range(120, 1));
            e2  = ($urandom % 3 == 0) ? -1 : int'($urandom_range(60, 1));
            rnd_wave();
            run_meas($sformatf("rnd%0d", t), win, tn, e2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
